// File: rtl/reg_scoreboard.sv
// Register-readiness scoreboard: per-register latency counters that interlock decode
// against pending long-latency results (load-use, mult/div) and WAW hazards.
module reg_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 4,
    parameter int unsigned PCW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid_DEC,
    input  logic [4:0]       rs_DEC,
    input  logic [4:0]       rt_DEC,
    input  logic             use_rs_DEC,
    input  logic             use_rt_DEC,
    input  logic [4:0]       dst_DEC,
    input  logic             wr_DEC,
    input  logic [CNTW-1:0]  lat_DEC,
    input  logic             flush,
    output logic             stall_DEC,
    output logic             issue_fire,
    output logic [NREGS-1:0] busy_vec,
    output logic [PCW-1:0]   stall_cycles
);

    logic [CNTW-1:0] cnt_q [NREGS];
    logic [CNTW-1:0] cnt_d [NREGS];

    logic rs_hazard;
    logic rt_hazard;
    logic waw_hazard;

    always_comb begin
        rs_hazard  = use_rs_DEC && (cnt_q[rs_DEC] != '0);
        rt_hazard  = use_rt_DEC && (cnt_q[rt_DEC] != '0);
        waw_hazard = wr_DEC && (cnt_q[dst_DEC] != '0);
        stall_DEC  = issue_valid_DEC && (rs_hazard || rt_hazard || waw_hazard);
        issue_fire = issue_valid_DEC && !stall_DEC;
    end

    always_comb begin
        for (int r = 0; r < int'(NREGS); r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    // Countdown first, then a new issue overrides its own entry; flush wins over both.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < int'(NREGS); r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNTW'(1) : '0;
        end
        if (issue_fire && wr_DEC && (dst_DEC != 5'd0) && (lat_DEC != '0)) begin
            cnt_d[dst_DEC] = lat_DEC;
        end
        if (flush) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NREGS); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_DEC && (stall_cycles != {PCW{1'b1}})) begin
            stall_cycles <= stall_cycles + PCW'(1);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a ready-time model predicts each cycle's outputs,
// a negedge monitor pops and compares. A second instance with PCW=4 covers saturation.
module tb_reg_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid_DEC;
    logic [4:0]  rs_DEC;
    logic [4:0]  rt_DEC;
    logic        use_rs_DEC;
    logic        use_rt_DEC;
    logic [4:0]  dst_DEC;
    logic        wr_DEC;
    logic [3:0]  lat_DEC;
    logic        flush;

    logic        stall_DEC;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    logic        stall_p4;
    logic        fire_p4;
    logic [31:0] busy_p4;
    logic [3:0]  stall_cycles_p4;

    reg_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid_DEC (issue_valid_DEC),
        .rs_DEC          (rs_DEC),
        .rt_DEC          (rt_DEC),
        .use_rs_DEC      (use_rs_DEC),
        .use_rt_DEC      (use_rt_DEC),
        .dst_DEC         (dst_DEC),
        .wr_DEC          (wr_DEC),
        .lat_DEC         (lat_DEC),
        .flush           (flush),
        .stall_DEC       (stall_DEC),
        .issue_fire      (issue_fire),
        .busy_vec        (busy_vec),
        .stall_cycles    (stall_cycles)
    );

    reg_scoreboard #(.PCW(4)) dut_p4 (
        .clk             (clk),
        .reset           (reset),
        .issue_valid_DEC (issue_valid_DEC),
        .rs_DEC          (rs_DEC),
        .rt_DEC          (rt_DEC),
        .use_rs_DEC      (use_rs_DEC),
        .use_rt_DEC      (use_rt_DEC),
        .dst_DEC         (dst_DEC),
        .wr_DEC          (wr_DEC),
        .lat_DEC         (lat_DEC),
        .flush           (flush),
        .stall_DEC       (stall_p4),
        .issue_fire      (fire_p4),
        .busy_vec        (busy_p4),
        .stall_cycles    (stall_cycles_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic [31:0] sc;
        logic [3:0]  sc4;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    bit          done    = 0;
    bit          armed   = 0;

    // Model: each register is busy until the cycle number stored in ready_at.
    longint      ready_at[32];
    longint      cyc = 0;
    int unsigned scm = 0;

    function automatic bit busy_m(input int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, $time / 10, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int dst, input bit wr,
                        input int lat, input bit fl);
        exp_t e;
        bit   st;
        reset           = rst;
        issue_valid_DEC = v;
        rs_DEC          = 5'(rs);
        rt_DEC          = 5'(rt);
        use_rs_DEC      = urs;
        use_rt_DEC      = urt;
        dst_DEC         = 5'(dst);
        wr_DEC          = wr;
        lat_DEC         = 4'(lat);
        flush           = fl;
        st = v && ((urs && busy_m(rs)) || (urt && busy_m(rt)) || (wr && busy_m(dst)));
        e.stall = st;
        e.fire  = v && !st;
        for (int r = 0; r < 32; r++) e.busy[r] = busy_m(r);
        e.sc  = scm;
        e.sc4 = (scm > 15) ? 4'd15 : 4'(scm);
        if (armed) sb.push_back(e);
        if (rst || fl) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
        end else if (e.fire && wr && dst != 0 && lat != 0) begin
            ready_at[dst] = cyc + 1 + longint'(lat);
        end
        if (rst) scm = 0;
        else if (st) scm++;
        if (rst) armed = 1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stall_DEC", 32'(stall_DEC), 32'(e.stall));
            chk("issue_fire", 32'(issue_fire), 32'(e.fire));
            chk("busy_vec", busy_vec, e.busy);
            chk("stall_cycles", stall_cycles, e.sc);
            chk("stall_DEC_p4", 32'(stall_p4), 32'(e.stall));
            chk("busy_vec_p4", busy_p4, e.busy);
            chk("stall_cycles_p4", 32'(stall_cycles_p4), 32'(e.sc4));
        end else if (done) begin
            chk("queue_drained", 32'(sb.size()), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        reset = 1; issue_valid_DEC = 0; rs_DEC = 0; rt_DEC = 0; use_rs_DEC = 0;
        use_rt_DEC = 0; dst_DEC = 0; wr_DEC = 0; lat_DEC = 0; flush = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset with busy state and a stall in flight
        step(0, 1, 0, 0, 0, 0, 4, 1, 9, 0);
        step(0, 1, 4, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 4, 0, 1, 0, 0, 0, 0, 0);
        // Load-use
        step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
        // Divide: consumer held on rt, then unused rt never stalls
        step(0, 1, 0, 0, 0, 0, 8, 1, 10, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 0, 8, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 8, 1, 10, 0);
        step(0, 1, 0, 8, 0, 0, 0, 0, 0, 0);
        idle(10);
        // dst=0 never busy
        step(0, 1, 0, 0, 0, 0, 0, 1, 15, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        // WAW, then flush beating a same-cycle fire
        step(0, 1, 0, 0, 0, 0, 3, 1, 2, 0);
        step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 3, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 8, 1, 6, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 4, 1);
        step(0, 1, 9, 8, 1, 1, 0, 0, 0, 0);
        // Long stall drives the 4-bit counter into saturation
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 10, 1, 15, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 10, 10, 1, 1, 10, 1, 15, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 10, 0, 1, 0, 0, 0, 0);
        // Random traffic on a small register set to force frequent hazards
        for (int i = 0; i < 3000; i++) begin
            int l;
            l = ($urandom_range(0, 9) < 4) ? 0 :
                (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                             : int'($urandom_range(1, 3)));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, l,
                 $urandom_range(0, 29) == 0);
        end
        idle(2);
        done = 1;
    end

endmodule
